gsm_ingress_tx: RTL and testbench



---
 rtl/gsm_ingress_tx.sv | 140 ++++++++++++++
 tb/tb_gsm_ingress_tx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gsm_ingress_tx.sv
// gsm_ingress_tx: TDM ingress arbiter with per-port free-list cell address allocation
module gsm_ingress_tx #(
    parameter int MWIDTH     = 4,
    parameter int LOG_MWIDTH = 2,
    parameter int DWIDTH     = 128,
    parameter int AWIDTH     = 7
) (
    input  logic                       clk_320M,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic [MWIDTH-1:0]          i_cell_valid,
    output logic [MWIDTH-1:0]          o_cell_ready,
    input  logic [MWIDTH*DWIDTH-1:0]   i_cell_data,
    input  logic [MWIDTH*MWIDTH-1:0]   i_cell_multicast,
    input  logic [MWIDTH-1:0]          i_buf_free,
    input  logic [MWIDTH*AWIDTH-1:0]   i_buf_free_addr,
    output logic [MWIDTH-1:0]          o_wr_en,
    output logic [MWIDTH*AWIDTH-1:0]   o_wr_addr,
    output logic [MWIDTH*MWIDTH-1:0]   o_multicast,
    output logic [MWIDTH-1:0]          o_common_sel,
    output logic [DWIDTH-1:0]          o_common_wr_data,
    output logic                       o_init_done,
    output logic [MWIDTH-1:0]          o_free_ovf
);
    localparam int DEPTH = 1 << AWIDTH;
    localparam logic [AWIDTH:0] FULL = {1'b1, {AWIDTH{1'b0}}};

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t                r_state, w_next;
    logic [AWIDTH-1:0]     r_seed;
    logic [LOG_MWIDTH-1:0] r_slot;
    logic [AWIDTH-1:0]     r_mem [MWIDTH][DEPTH];
    logic [AWIDTH-1:0]     r_rd [MWIDTH];
    logic [AWIDTH-1:0]     r_wr [MWIDTH];
    logic [AWIDTH:0]       r_cnt [MWIDTH];
    logic [AWIDTH-1:0]     w_head [MWIDTH];
    logic [AWIDTH-1:0]     w_push_addr [MWIDTH];
    logic [MWIDTH-1:0]     w_pop, w_push, w_ovf;
    logic [DWIDTH-1:0]     w_data;
    logic                  w_run;

    assign w_run        = (r_state == S_RUN);
    assign o_init_done  = w_run;
    assign o_common_sel = w_run ? (MWIDTH'(1) << r_slot) : '0;

    // A pop needs a non-empty list, the port's slot and a live destination vector;
    // a full list still accepts a return when the same cycle pops it.
    for (genvar g = 0; g < MWIDTH; g++) begin : g_port
        assign w_head[g]       = r_mem[g][r_rd[g]];
        assign o_cell_ready[g] = w_run && (r_slot == LOG_MWIDTH'(g)) && (r_cnt[g] != '0);
        assign w_pop[g]        = o_cell_ready[g] && i_cell_valid[g] && !clr
                                 && (|i_cell_multicast[g*MWIDTH +: MWIDTH]);
        assign w_push[g]       = !clr && (!w_run || (i_buf_free[g] && ((r_cnt[g] != FULL) || w_pop[g])));
        assign w_ovf[g]        = !clr && w_run && i_buf_free[g] && (r_cnt[g] == FULL) && !w_pop[g];
        assign w_push_addr[g]  = w_run ? i_buf_free_addr[g*AWIDTH +: AWIDTH] : r_seed;
    end

    // Next state: seeding finishes after the last address is pushed; clr always restarts it
    always_comb begin
        w_next = r_state;
        if (clr)
            w_next = S_INIT;
        else if (!w_run && (&r_seed))
            w_next = S_RUN;
    end

    // Common bus data comes from the single port popping this cycle, else zero
    always_comb begin
        w_data = '0;
        for (int p = 0; p < MWIDTH; p++)
            if (w_pop[p]) w_data = i_cell_data[p*DWIDTH +: DWIDTH];
    end

    // State, seed counter and TDM slot
    always_ff @(posedge clk_320M or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_INIT;
            r_seed  <= '0;
            r_slot  <= '0;
        end else begin
            r_state <= w_next;
            r_seed  <= (w_run || clr) ? '0 : r_seed + 1'b1;
            r_slot  <= (w_run && !clr) ? r_slot + 1'b1 : '0;
        end
    end

    // Free-list storage; contents are only meaningful between the pointers
    always_ff @(posedge clk_320M) begin
        for (int p = 0; p < MWIDTH; p++)
            if (w_push[p]) r_mem[p][r_wr[p]] <= w_push_addr[p];
    end

    // Free-list pointers and occupancy
    always_ff @(posedge clk_320M or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < MWIDTH; p++) begin
                r_rd[p]  <= '0;
                r_wr[p]  <= '0;
                r_cnt[p] <= '0;
            end
        end else begin
            for (int p = 0; p < MWIDTH; p++) begin
                if (clr) begin
                    r_rd[p]  <= '0;
                    r_wr[p]  <= '0;
                    r_cnt[p] <= '0;
                end else begin
                    r_rd[p]  <= r_rd[p] + AWIDTH'(w_pop[p]);
                    r_wr[p]  <= r_wr[p] + AWIDTH'(w_push[p]);
                    r_cnt[p] <= r_cnt[p] + (AWIDTH+1)'(w_push[p]) - (AWIDTH+1)'(w_pop[p]);
                end
            end
        end
    end

    // Registered write-side outputs; address and multicast hold between writes
    always_ff @(posedge clk_320M or negedge rst_n) begin
        if (!rst_n) begin
            o_wr_en          <= '0;
            o_wr_addr        <= '0;
            o_multicast      <= '0;
            o_common_wr_data <= '0;
            o_free_ovf       <= '0;
        end else begin
            o_wr_en          <= w_pop;
            o_common_wr_data <= w_data;
            o_free_ovf       <= clr ? '0 : (o_free_ovf | w_ovf);
            for (int p = 0; p < MWIDTH; p++) begin
                if (clr) begin
                    o_wr_addr[p*AWIDTH +: AWIDTH]   <= '0;
                    o_multicast[p*MWIDTH +: MWIDTH] <= '0;
                end else if (w_pop[p]) begin
                    o_wr_addr[p*AWIDTH +: AWIDTH]   <= w_head[p];
                    o_multicast[p*MWIDTH +: MWIDTH] <= i_cell_multicast[p*MWIDTH +: MWIDTH];
                end
            end
        end
    end
endmodule

// File: tb/tb_gsm_ingress_tx.sv
// tb_gsm_ingress_tx: vector table, directed corner sequences and random traffic against a queue model
module tb_gsm_ingress_tx;
    localparam int M = 4;
    localparam int D = 128;
    localparam int A = 7;
    localparam int DEPTH = 128;

    logic             clk_320M = 1'b0;
    logic             rst_n = 1'b0;
    logic             clr = 1'b0;
    logic [M-1:0]     i_cell_valid = '0;
    logic [M*D-1:0]   i_cell_data = '0;
    logic [M*M-1:0]   i_cell_multicast = '0;
    logic [M-1:0]     i_buf_free = '0;
    logic [M*A-1:0]   i_buf_free_addr = '0;
    logic [M-1:0]     o_cell_ready, o_wr_en, o_common_sel, o_free_ovf;
    logic [M*A-1:0]   o_wr_addr;
    logic [M*M-1:0]   o_multicast;
    logic [D-1:0]     o_common_wr_data;
    logic             o_init_done;

    gsm_ingress_tx dut (
        .clk_320M(clk_320M), .rst_n(rst_n), .clr(clr),
        .i_cell_valid(i_cell_valid), .o_cell_ready(o_cell_ready),
        .i_cell_data(i_cell_data), .i_cell_multicast(i_cell_multicast),
        .i_buf_free(i_buf_free), .i_buf_free_addr(i_buf_free_addr),
        .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_multicast(o_multicast),
        .o_common_sel(o_common_sel), .o_common_wr_data(o_common_wr_data),
        .o_init_done(o_init_done), .o_free_ovf(o_free_ovf)
    );

    always #5 clk_320M = ~clk_320M;

    // Reference model: one address queue per port, a countdown for seeding, a slot index
    typedef logic [A-1:0] addr_q_t[$];
    addr_q_t        q [M];
    int             m_init;
    int             m_slot;
    logic [M-1:0]   e_wr_en, e_ovf;
    logic [M*A-1:0] e_wr_addr;
    logic [M*M-1:0] e_mc;
    logic [D-1:0]   e_data;
    int             n_checks = 0;
    int             n_fail = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int p = 0; p < M; p++) q[p].delete();
        m_init = DEPTH;
        m_slot = 0;
        e_wr_en = '0;
        e_ovf = '0;
        e_wr_addr = '0;
        e_mc = '0;
        e_data = '0;
    endfunction

    function automatic void model_step();
        int p;
        if (clr) begin
            model_reset();
            return;
        end
        e_wr_en = '0;
        e_data = '0;
        if (m_init > 0) begin
            for (int r = 0; r < M; r++) q[r].push_back(A'(DEPTH - m_init));
            m_init--;
            return;
        end
        p = m_slot;
        if (i_cell_valid[p] && q[p].size() > 0 && i_cell_multicast[p*M +: M] != '0) begin
            e_wr_en[p] = 1'b1;
            e_wr_addr[p*A +: A] = q[p].pop_front();
            e_mc[p*M +: M] = i_cell_multicast[p*M +: M];
            e_data = i_cell_data[p*D +: D];
        end
        for (int r = 0; r < M; r++)
            if (i_buf_free[r]) begin
                if (q[r].size() < DEPTH) q[r].push_back(i_buf_free_addr[r*A +: A]);
                else e_ovf[r] = 1'b1;
            end
        m_slot = (m_slot + 1) % M;
    endfunction

    task automatic check_outputs();
        logic [M-1:0] er;
        er = '0;
        if (m_init == 0)
            for (int p = 0; p < M; p++) er[p] = (m_slot == p) && (q[p].size() > 0);
        chk("ready", o_cell_ready, er);
        chk("sel", o_common_sel, (m_init == 0) ? (4'b0001 << m_slot) : 4'b0000);
        chk("init_done", o_init_done, m_init == 0);
        chk("wr_en", o_wr_en, e_wr_en);
        chk("wr_addr", o_wr_addr, e_wr_addr);
        chk("multicast", o_multicast, e_mc);
        chk("data", o_common_wr_data, e_data);
        chk("free_ovf", o_free_ovf, e_ovf);
        chk("wr_en_onehot", $countones(o_wr_en) <= 1, 1);
    endtask

    // Called at a negedge with inputs already set; returns at the next negedge
    task automatic tick();
        #1;
        check_outputs();
        model_step();
        @(negedge clk_320M);
    endtask

    typedef struct packed {
        logic [3:0]  valid;
        logic [15:0] mc;
        logic [3:0]  sel;
        logic [3:0]  ready;
        logic [3:0]  wr_en;
        logic [7:0]  dbyte;
        logic [6:0]  addr;
    } vec_t;
    vec_t tbl [12];

    initial begin
        int port;
        tbl[0]  = '{4'b0100, 16'h0500, 4'b0001, 4'b0001, 4'b0000, 8'h00, 7'd0};
        tbl[1]  = '{4'b0100, 16'h0500, 4'b0010, 4'b0010, 4'b0000, 8'h00, 7'd0};
        tbl[2]  = '{4'b0100, 16'h0500, 4'b0100, 4'b0100, 4'b0000, 8'h00, 7'd0};
        tbl[3]  = '{4'b0000, 16'h0000, 4'b1000, 4'b1000, 4'b0100, 8'hA5, 7'd0};
        tbl[4]  = '{4'b1111, 16'h5555, 4'b0001, 4'b0001, 4'b0000, 8'h00, 7'd0};
        tbl[5]  = '{4'b1111, 16'h5555, 4'b0010, 4'b0010, 4'b0001, 8'h10, 7'd0};
        tbl[6]  = '{4'b1111, 16'h5555, 4'b0100, 4'b0100, 4'b0010, 8'h11, 7'd0};
        tbl[7]  = '{4'b1111, 16'h5555, 4'b1000, 4'b1000, 4'b0100, 8'hA5, 7'd1};
        tbl[8]  = '{4'b1111, 16'h5555, 4'b0001, 4'b0001, 4'b1000, 8'h13, 7'd0};
        tbl[9]  = '{4'b0010, 16'h5505, 4'b0010, 4'b0010, 4'b0001, 8'h10, 7'd1};
        tbl[10] = '{4'b0000, 16'h0000, 4'b0100, 4'b0100, 4'b0000, 8'h00, 7'd0};
        tbl[11] = '{4'b0000, 16'h0000, 4'b1000, 4'b1000, 4'b0000, 8'h00, 7'd0};
        for (int p = 0; p < M; p++)
            i_cell_data[p*D +: D] = {16{(p == 2) ? 8'hA5 : 8'(8'h10 + p)}};
        model_reset();

        repeat (2) @(negedge clk_320M);
        chk("rst_wr_en", o_wr_en, 0);
        chk("rst_sel", o_common_sel, 0);
        chk("rst_init_done", o_init_done, 0);
        chk("rst_ready", o_cell_ready, 0);
        chk("rst_data", o_common_wr_data, 0);
        rst_n = 1'b1;

        for (int i = 0; i < DEPTH; i++) tick();
        chk("init_done_rise", o_init_done, 1);

        for (int i = 0; i < 12; i++) begin
            i_cell_valid = tbl[i].valid;
            i_cell_multicast = tbl[i].mc;
            #1;
            chk("tbl_sel", o_common_sel, tbl[i].sel);
            chk("tbl_ready", o_cell_ready, tbl[i].ready);
            chk("tbl_wr_en", o_wr_en, tbl[i].wr_en);
            chk("tbl_data", o_common_wr_data, (tbl[i].dbyte == 8'h00) ? 128'h0 : {16{tbl[i].dbyte}});
            port = -1;
            for (int p = 0; p < M; p++) if (tbl[i].wr_en[p]) port = p;
            if (port >= 0) chk("tbl_addr", o_wr_addr[port*A +: A], tbl[i].addr);
            tick();
        end

        i_cell_valid = 4'b0001;
        i_cell_multicast = 16'h0001;
        for (int i = 0; i < 600 && q[0].size() > 0; i++) tick();
        while (m_slot != 0) tick();
        #1;
        chk("empty_ready0", o_cell_ready[0], 0);
        tick();
        i_buf_free = 4'b0001;
        i_buf_free_addr[0 +: A] = 7'h37;
        tick();
        i_buf_free = '0;
        for (int i = 0; i < 8 && !o_wr_en[0]; i++) tick();
        chk("ret_seen", o_wr_en[0], 1);
        chk("ret_addr", o_wr_addr[0 +: A], 7'h37);
        i_cell_valid = '0;

        i_buf_free = 4'b0010;
        i_buf_free_addr[A +: A] = 7'h05;
        tick();
        tick();
        i_buf_free = '0;
        chk("ovf_set", o_free_ovf, 4'b0010);
        while (m_slot != 1) tick();
        i_cell_valid = 4'b0010;
        i_cell_multicast = 16'h00F0;
        i_buf_free = 4'b0010;
        i_buf_free_addr[A +: A] = 7'h06;
        tick();
        i_cell_valid = '0;
        i_buf_free = '0;
        chk("pushpop_wr_en", o_wr_en, 4'b0010);
        chk("ovf_hold", o_free_ovf, 4'b0010);
        tick();

        for (int i = 0; i < 400; i++) begin
            i_cell_valid = 4'($urandom);
            i_cell_multicast = 16'($urandom) & {4{4'($urandom)}};
            i_buf_free = 4'($urandom) & 4'($urandom);
            i_buf_free_addr = 28'($urandom);
            for (int w = 0; w < M*D/32; w++) i_cell_data[w*32 +: 32] = $urandom;
            tick();
        end

        i_cell_valid = 4'b1111;
        i_cell_multicast = 16'h5555;
        i_buf_free = '0;
        tick();
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_wr_en", o_wr_en, 0);
        chk("clr_init_done", o_init_done, 0);
        chk("clr_sel", o_common_sel, 0);
        chk("clr_ovf", o_free_ovf, 0);
        for (int i = 0; i < DEPTH; i++) begin
            i_buf_free = 4'($urandom);
            i_buf_free_addr = 28'($urandom);
            tick();
        end
        i_buf_free = '0;
        chk("reinit_done", o_init_done, 1);
        tick();
        chk("realloc_wr_en", o_wr_en, 4'b0001);
        chk("realloc_addr", o_wr_addr[0 +: A], 7'd0);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
